// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multi-cycle unsigned dw x dw -> 2*dw multiplier that borrows the shared ALU.
// It computes by shift-and-add using only the ALU's add, pass and right-shift operations.
// The accumulator lives in the ALU OUT register. While busy is high this block owns the
// ALU inputs through the external mux.
//
// Optional feature: define ALU_MUL_SEQ_EARLY_EXIT_EN to skip the pass cycle for zero
// multiplier bits. Latency becomes dw + popcount(b) + 2 instead of 2*dw + 2.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   start, a, b            multiply request and operands (sampled in idle only)
//   busy, done             sequencer active / one-cycle completion pulse
//   product_hi/lo          product halves, valid from done and held until the next done
//   alu_op/right/AI/BI/CI  ALU operation and operands driven while busy
//   alu_BCD, alu_RDY       BCD select (always 0) and ALU register enable
//   alu_OUT, alu_CO        registered ALU result and carry
module alu_mul_seq #(
    parameter int dw = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [dw-1:0] a,
    input  logic [dw-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [dw-1:0] product_hi,
    output logic [dw-1:0] product_lo,
    output logic [3:0]    alu_op,
    output logic          alu_right,
    output logic [dw-1:0] alu_AI,
    output logic [dw-1:0] alu_BI,
    output logic          alu_CI,
    output logic          alu_BCD,
    output logic          alu_RDY,
    input  logic [dw-1:0] alu_OUT,
    input  logic          alu_CO
);

    localparam int CntW = $clog2(dw) + 1;
    localparam logic [3:0] OpAdd  = 4'b0011;
    localparam logic [3:0] OpPass = 4'b1111;

    typedef enum logic [2:0] {StIdle, StLoad, StAdd, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [dw-1:0]     mcand_q;
    logic [dw-1:0]     plo_q;
    logic [CntW-1:0]   cnt_q;
    logic              added_q;
    logic [dw-1:0]     prod_hi_q, prod_lo_q;
    logic              shift_en;
    logic              last_bit;

    assign last_bit = (cnt_q == CntW'(1));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StLoad;
            StLoad:  state_d = StAdd;
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
            StAdd: begin
                if (plo_q[0]) state_d = StShift;
                else          state_d = last_bit ? StDone : StAdd;
            end
`else
            StAdd:   state_d = StShift;
`endif
            StShift: state_d = last_bit ? StDone : StAdd;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        alu_op    = 4'b0000;
        alu_right = 1'b0;
        alu_AI    = '0;
        alu_BI    = '0;
        alu_CI    = 1'b0;
        alu_RDY   = 1'b0;
        shift_en  = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StIdle: ;
            StLoad: begin
                // Pass of zero clears the accumulator in the ALU OUT register.
                alu_op  = OpPass;
                alu_RDY = 1'b1;
            end
            StAdd: begin
                alu_AI  = alu_OUT;
                alu_RDY = 1'b1;
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
                if (plo_q[0]) begin
                    alu_BI = mcand_q;
                    alu_op = OpAdd;
                end else begin
                    // Zero bit: shift straight away, nothing was added so carry-in is 0.
                    alu_op    = OpPass;
                    alu_right = 1'b1;
                    shift_en  = 1'b1;
                end
`else
                alu_BI = mcand_q;
                alu_op = plo_q[0] ? OpAdd : OpPass;
`endif
            end
            StShift: begin
                // Carry out of the add becomes the new top bit of the accumulator.
                alu_AI    = alu_OUT;
                alu_op    = OpPass;
                alu_right = 1'b1;
                alu_CI    = added_q & alu_CO;
                alu_RDY   = 1'b1;
                shift_en  = 1'b1;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    assign busy    = (state_q != StIdle);
    assign alu_BCD = 1'b0;

    // The final high half is still in the ALU during the done cycle, so present it directly.
    assign product_hi = (state_q == StDone) ? alu_OUT : prod_hi_q;
    assign product_lo = (state_q == StDone) ? plo_q   : prod_lo_q;

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q   <= '0;
            plo_q     <= '0;
            cnt_q     <= '0;
            added_q   <= 1'b0;
            prod_hi_q <= '0;
            prod_lo_q <= '0;
        end else begin
            if (state_q == StIdle && start) begin
                mcand_q <= a;
                plo_q   <= b;
                cnt_q   <= CntW'(dw);
            end
            if (state_q == StAdd) begin
                added_q <= plo_q[0];
            end
            if (shift_en) begin
                // Bit shifted out of the accumulator lands at the top of the low half.
                plo_q <= {alu_OUT[0], plo_q[dw-1:1]};
                cnt_q <= cnt_q - CntW'(1);
            end
            if (state_q == StDone) begin
                prod_hi_q <= alu_OUT;
                prod_lo_q <= plo_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [DW-1:0] a, b;
    logic          busy, done;
    logic [DW-1:0] product_hi, product_lo;
    logic [3:0]    alu_op;
    logic          alu_right, alu_CI, alu_BCD, alu_RDY;
    logic [DW-1:0] alu_AI, alu_BI;
    logic [DW-1:0] m_out = '0;
    logic          m_co = 1'b0;

    alu_mul_seq #(.dw(DW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .product_hi (product_hi),
        .product_lo (product_lo),
        .alu_op     (alu_op),
        .alu_right  (alu_right),
        .alu_AI     (alu_AI),
        .alu_BI     (alu_BI),
        .alu_CI     (alu_CI),
        .alu_BCD    (alu_BCD),
        .alu_RDY    (alu_RDY),
        .alu_OUT    (m_out),
        .alu_CO     (m_co)
    );

    always #5 clk = ~clk;

    // Behavioural model of the shared ALU: result registered one cycle after issue.
    always_ff @(posedge clk) begin
        if (alu_RDY) begin
            if (alu_right) begin
                m_out <= {alu_CI, alu_AI[DW-1:1]};
                m_co  <= alu_AI[0];
            end else if (alu_op == 4'b0011) begin
                {m_co, m_out} <= {1'b0, alu_AI} + {1'b0, alu_BI} + (DW+1)'(alu_CI);
            end else begin
                m_out <= alu_AI;
                m_co  <= 1'b0;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
        int            lat;
        int            acc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever done is presented.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("product_hi", 32'(product_hi), 32'(e.hi));
                    chk("product_lo", 32'(product_lo), 32'(e.lo));
                    chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                    @(negedge clk);
                    chk("done_pulse", 32'(done), 32'd0);
                    chk("busy_falls", 32'(busy), 32'd0);
                    chk("hold_hi", 32'(product_hi), 32'(e.hi));
                    chk("hold_lo", 32'(product_lo), 32'(e.lo));
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) break;
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    function automatic int pick_lat(input int lat_off, input int lat_on);
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
        return lat_on;
`else
        return lat_off;
`endif
    endfunction

    task automatic mul(input logic [DW-1:0] ta, input logic [DW-1:0] tb,
                       input logic [DW-1:0] eh, input logic [DW-1:0] el,
                       input int lat_off, input int lat_on);
        exp_t e;
        wait_idle();
        start = 1'b1;
        a     = ta;
        b     = tb;
        e.hi  = eh;
        e.lo  = el;
        e.lat = pick_lat(lat_off, lat_on);
        e.acc = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        drain();
    endtask

    initial begin
        exp_t e;
        int   n;
        reset_n = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hi", 32'(product_hi), 32'd0);
        chk("rst_lo", 32'(product_lo), 32'd0);
        chk("rst_op", 32'(alu_op), 32'd0);
        chk("rst_rdy", 32'(alu_RDY), 32'd0);
        chk("rst_ai_bi", {alu_AI, alu_BI}, 32'd0);
        chk("rst_misc", 32'({alu_right, alu_CI, alu_BCD}), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        mul(16'h0003, 16'h0005, 16'h0000, 16'h000F, 34, 20);
        mul(16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 34, 34);

        // Abort a multiply with reset ten cycles in; no done may follow.
        wait_idle();
        start = 1'b1;
        a     = 16'h0007;
        b     = 16'h0009;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_hi", 32'(product_hi), 32'd0);
        chk("abort_lo", 32'(product_lo), 32'd0);
        chk("abort_rdy", 32'(alu_RDY), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);

        mul(16'h1234, 16'h0000, 16'h0000, 16'h0000, 34, 18);

        // start held through the run; operands change mid-run.
        wait_idle();
        start = 1'b1;
        a     = 16'h00FF;
        b     = 16'h0101;
        e.hi  = 16'h0000;
        e.lo  = 16'hFFFF;
        e.lat = pick_lat(34, 20);
        e.acc = cyc + 1;
        exp_q.push_back(e);
        repeat (10) @(negedge clk);
        a = 16'h1000;
        b = 16'h0010;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("held_done_timeout", 32'(done), 32'd1);
        // Second operation may only be accepted at the edge ending the first idle cycle.
        e.hi  = 16'h0001;
        e.lo  = 16'h0000;
        e.lat = pick_lat(34, 19);
        e.acc = cyc + 2;
        exp_q.push_back(e);
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        drain();

        mul(16'h0100, 16'h8001, 16'h0080, 16'h0100, 34, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
